sr_ff_bank: RTL and testbench

Parametrised bank of WIDTH clocked set/reset storage bits, each usable as an SR, JK, D or T flip-flop through a shared run-time mode select. It is the multi-channel successor of the single SR flip-flop. Set+reset conflicts resolve deterministically, never to high-impedance, and are reported through sticky error status. It sits between control/decode logic and status or flag consumers that need per-bit set/clear/toggle semantics.

---
 rtl/sr_ff_bank_if.sv | 51 +++++
 rtl/sr_ff_bank.sv | 141 ++++++++++++++
 tb/tb_sr_ff_bank.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sr_ff_bank_if.sv
// sr_ff_bank_if -- control/status bundle for the sr_ff_bank flip-flop bank.
//
// Optional feature macro: SRFFB_ERRCNT_EN (adds the err_cnt counter signal).
//
// Signals:
//   en          global update enable
//   mode        2-bit mode select: 00 SR, 01 JK, 10 D, 11 T
//   s, r        per-channel S/J/D/T and R/K inputs
//   err_clr     clears the sticky error status (and counter)
//   q, qbar     registered state and its complement
//   chg         per-channel one-cycle change flags
//   err_sticky  sticky SR-conflict flag
//   err_cnt     saturating conflict counter (SRFFB_ERRCNT_EN only)
//
// Modports: master drives the controls and reads the status,
//           slave is the flip-flop bank itself.
interface sr_ff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] chg;
    logic             err_sticky;
`ifdef SRFFB_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output en, mode, s, r, err_clr,
        input  q, qbar, chg, err_sticky, err_cnt
    );
    modport slave (
        input  en, mode, s, r, err_clr,
        output q, qbar, chg, err_sticky, err_cnt
    );
`else
    modport master (
        output en, mode, s, r, err_clr,
        input  q, qbar, chg, err_sticky
    );
    modport slave (
        input  en, mode, s, r, err_clr,
        output q, qbar, chg, err_sticky
    );
`endif
endinterface

// File: rtl/sr_ff_bank.sv
// sr_ff_bank -- WIDTH independent clocked storage bits, each acting as an
// SR, JK, D or T flip-flop according to a shared run-time mode select.
// SR-mode set+reset conflicts resolve per PRIORITY and raise a sticky
// error flag.
//
// Optional feature macro: SRFFB_ERRCNT_EN (adds a saturating conflict
// counter err_cnt of CNT_W bits).
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high; overrides every other input
//   bus   sr_ff_bank_if.slave: en, mode, s, r, err_clr in;
//         q, qbar, chg, err_sticky (, err_cnt) out
//
// Parameters:
//   WIDTH      number of channels (1..64)
//   RESET_VAL  value loaded into q on reset
//   PRIORITY   SR conflict resolution: 0 hold, 1 set wins, 2 reset wins
//   CNT_W      width of err_cnt
module sr_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               PRIORITY  = 0,
    parameter int               CNT_W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    sr_ff_bank_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    if (PRIORITY < 0 || PRIORITY > 2) begin : g_bad_priority
        $error("sr_ff_bank: PRIORITY must be 0, 1 or 2");
    end

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("sr_ff_bank: WIDTH must be in 1..64");
    end

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] chg_r;
    logic             sticky_r;
    logic             viol;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    // A conflict is only meaningful in SR mode; JK uses s=r=1 as toggle.
    assign viol = bus.en && (mode == MODE_SR) && (|(bus.s & bus.r));

    // Next-state per channel. With en low every channel holds, so the
    // change flags below fall out naturally as zero.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // q_next unassigned, which would otherwise infer a latch.
        q_next = q_r;
        if (bus.en) begin
            for (int i = 0; i < WIDTH; i++) begin
                unique case (mode)
                    MODE_SR: begin
                        unique case ({bus.s[i], bus.r[i]})
                            2'b00: q_next[i] = q_r[i];
                            2'b01: q_next[i] = 1'b0;
                            2'b10: q_next[i] = 1'b1;
                            2'b11: begin
                                if (PRIORITY == 1)
                                    q_next[i] = 1'b1;
                                else if (PRIORITY == 2)
                                    q_next[i] = 1'b0;
                                else
                                    q_next[i] = q_r[i];
                            end
                        endcase
                    end
                    MODE_JK: begin
                        unique case ({bus.s[i], bus.r[i]})
                            2'b00: q_next[i] = q_r[i];
                            2'b01: q_next[i] = 1'b0;
                            2'b10: q_next[i] = 1'b1;
                            2'b11: q_next[i] = ~q_r[i];
                        endcase
                    end
                    MODE_D:  q_next[i] = bus.s[i];
                    MODE_T:  q_next[i] = bus.s[i] ? ~q_r[i] : q_r[i];
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r      <= RESET_VAL;
            chg_r    <= '0;
            sticky_r <= 1'b0;
        end else begin
            q_r   <= q_next;
            chg_r <= q_next ^ q_r;
            // A violation in the same cycle as err_clr wins.
            if (viol)
                sticky_r <= 1'b1;
            else if (bus.err_clr)
                sticky_r <= 1'b0;
        end
    end

`ifdef SRFFB_ERRCNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Counts conflict cycles, not conflicting bits; saturates at all-ones.
    // Clear plus violation in the same cycle restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (viol && bus.err_clr) begin
            cnt_r <= CNT_W'(1);
        end else if (viol) begin
            if (cnt_r != '1)
                cnt_r <= cnt_r + CNT_W'(1);
        end else if (bus.err_clr) begin
            cnt_r <= '0;
        end
    end

    assign bus.err_cnt = cnt_r;
`endif

    assign bus.q          = q_r;
    assign bus.qbar       = ~q_r;
    assign bus.chg        = chg_r;
    assign bus.err_sticky = sticky_r;

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank -- self-checking bench for sr_ff_bank with WIDTH=4,
// RESET_VAL=4'b1010, PRIORITY=1 (set-dominant), CNT_W=2.
// Expected values are pushed to a scoreboard queue when each cycle's
// stimulus is driven and popped after the following rising edge.
// err_cnt is compared only when SRFFB_ERRCNT_EN is defined.
module tb_sr_ff_bank;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [3:0] s;
        logic [3:0] r;
        logic       clr;
        logic [3:0] eq;
        logic [3:0] echg;
        logic       esticky;
        logic [1:0] ecnt;
    } step_t;

    typedef struct {
        logic [3:0] q;
        logic [3:0] chg;
        logic       sticky;
        logic [1:0] cnt;
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];

    sr_ff_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    sr_ff_bank #(
        .WIDTH    (WIDTH),
        .RESET_VAL(4'b1010),
        .PRIORITY (1),
        .CNT_W    (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (actual=timeout required=done)");
        $fatal(1);
    end

    // Drive one cycle of stimulus on the falling edge and record what the
    // bank must show after the next rising edge.
    task automatic drive(input step_t st, input string name);
        exp_t e;
        @(negedge clk);
        rst         = st.rst;
        bus.en      = st.en;
        bus.mode    = st.mode;
        bus.s       = st.s;
        bus.r       = st.r;
        bus.err_clr = st.clr;
        e.q      = st.eq;
        e.chg    = st.echg;
        e.sticky = st.esticky;
        e.cnt    = st.ecnt;
        e.name   = name;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        step_t st;
        exp_t  e;
        st = '{1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 4'b1010, 4'b0000, 1'b0, 2'd0};
        drive(st, "reset");
        @(posedge clk); #1;
        e = sb.pop_front();
        total++;
        if ({bus.q, bus.qbar, bus.chg, bus.err_sticky} !== {e.q, ~e.q, e.chg, e.sticky}) begin
            bad++;
            $display("FAIL %s: q/qbar/chg/sticky actual=%h/%h/%h/%b required=%h/%h/%h/%b",
                     e.name, bus.q, bus.qbar, bus.chg, bus.err_sticky, e.q, ~e.q, e.chg, e.sticky);
        end
`ifdef SRFFB_ERRCNT_EN
        total++;
        if (bus.err_cnt !== e.cnt) begin
            bad++;
            $display("FAIL %s cnt: actual=%0d required=%0d", e.name, bus.err_cnt, e.cnt);
        end
`endif
    endtask

    // Run a sequence of steps, comparing every cycle against the scoreboard.
    task automatic test_seq(input step_t steps[$], input string name);
        exp_t e;
        foreach (steps[k]) begin
            drive(steps[k], $sformatf("%s[%0d]", name, k));
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s: scoreboard empty (actual=0 required=1)", name);
            end else begin
                e = sb.pop_front();
                total++;
                if ({bus.q, bus.qbar, bus.chg, bus.err_sticky} !== {e.q, ~e.q, e.chg, e.sticky}) begin
                    bad++;
                    $display("FAIL %s: q/qbar/chg/sticky actual=%h/%h/%h/%b required=%h/%h/%h/%b",
                             e.name, bus.q, bus.qbar, bus.chg, bus.err_sticky,
                             e.q, ~e.q, e.chg, e.sticky);
                end
`ifdef SRFFB_ERRCNT_EN
                total++;
                if (bus.err_cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL %s cnt: actual=%0d required=%0d", e.name, bus.err_cnt, e.cnt);
                end
`endif
            end
        end
    endtask

    //                rst   en    mode   s      r      clr   q        chg      stk   cnt
    task automatic test_sr_mode();
        step_t st[$];
        st.push_back('{1'b0, 1'b1, 2'b00, 4'b0001, 4'b1000, 1'b0, 4'b0011, 4'b1001, 1'b0, 2'd0});
        st.push_back('{1'b0, 1'b0, 2'b00, 4'b1111, 4'b0000, 1'b0, 4'b0011, 4'b0000, 1'b0, 2'd0});
        test_seq(st, "sr_mode");
    endtask

    task automatic test_sr_conflict();
        step_t st[$];
        st.push_back('{1'b0, 1'b1, 2'b00, 4'b0100, 4'b0100, 1'b0, 4'b0111, 4'b0100, 1'b1, 2'd1});
        st.push_back('{1'b0, 1'b1, 2'b00, 4'b0100, 4'b0100, 1'b0, 4'b0111, 4'b0000, 1'b1, 2'd2});
        st.push_back('{1'b0, 1'b1, 2'b00, 4'b0100, 4'b0100, 1'b0, 4'b0111, 4'b0000, 1'b1, 2'd3});
        st.push_back('{1'b0, 1'b1, 2'b00, 4'b0100, 4'b0100, 1'b0, 4'b0111, 4'b0000, 1'b1, 2'd3});
        st.push_back('{1'b0, 1'b0, 2'b00, 4'b0100, 4'b0100, 1'b1, 4'b0111, 4'b0000, 1'b0, 2'd0});
        test_seq(st, "sr_conflict");
    endtask

    task automatic test_jk_toggle();
        step_t st[$];
        st.push_back('{1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 1'b0, 2'd0});
        st.push_back('{1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0, 4'b0101, 4'b1111, 1'b0, 2'd0});
        st.push_back('{1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0, 4'b1010, 4'b1111, 1'b0, 2'd0});
        test_seq(st, "jk_toggle");
    endtask

    task automatic test_d_then_t();
        step_t st[$];
        st.push_back('{1'b0, 1'b1, 2'b10, 4'b0110, 4'b1001, 1'b0, 4'b0110, 4'b1100, 1'b0, 2'd0});
        st.push_back('{1'b0, 1'b1, 2'b11, 4'b0011, 4'b1111, 1'b0, 4'b0101, 4'b0011, 1'b0, 2'd0});
        test_seq(st, "d_then_t");
    endtask

    task automatic test_simultaneous();
        step_t st[$];
        st.push_back('{1'b0, 1'b1, 2'b00, 4'b0001, 4'b0001, 1'b1, 4'b0101, 4'b0000, 1'b1, 2'd1});
        st.push_back('{1'b1, 1'b1, 2'b10, 4'b1111, 4'b0000, 1'b0, 4'b1010, 4'b0000, 1'b0, 2'd0});
        test_seq(st, "simultaneous");
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.mode    = 2'b00;
        bus.s       = '0;
        bus.r       = '0;
        bus.err_clr = 1'b0;

        test_reset();
        test_sr_mode();
        test_sr_conflict();
        test_jk_toggle();
        test_d_then_t();
        test_simultaneous();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
